// File: rtl/alu32_serial_ctrl_if.sv
// Bundle of the command, byte-ALU and response signals of the serial wide ALU controller.
interface alu32_serial_ctrl_if #(
    parameter int NBYTES = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [8*NBYTES-1:0]   cmd_a;
    logic [8*NBYTES-1:0]   cmd_b;
    logic                  cmd_cin;
    logic [1:0]            cmd_op;

    logic [7:0]            alu_a;
    logic [7:0]            alu_b;
    logic                  alu_cin;
    logic [1:0]            alu_op;
    logic [7:0]            alu_result;
    logic                  alu_cout;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [8*NBYTES-1:0]   rsp_result;
    logic                  rsp_cout;
    logic                  rsp_zero;

    // Environment side: issues commands, provides the byte ALU, consumes responses.
    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_cin, cmd_op, alu_result, alu_cout, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_cin, alu_op, rsp_valid, rsp_result, rsp_cout, rsp_zero
    );

    // Controller side.
    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_cin, cmd_op, alu_result, alu_cout, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_cin, alu_op, rsp_valid, rsp_result, rsp_cout, rsp_zero
    );
endinterface

// File: rtl/alu32_serial_ctrl.sv
// Serial wide-ALU controller: feeds an external 8-bit ALU one byte slice per cycle,
// chaining the carry between slices, and returns the assembled wide result.
module alu32_serial_ctrl #(
    parameter int NBYTES = 4
) (
    input logic                clk,
    input logic                rst,
    alu32_serial_ctrl_if.slave bus
);
    localparam int W     = 8 * NBYTES;
    localparam int IDX_W = $clog2(NBYTES) + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [W-1:0]     a_q, b_q, res_q;
    logic [1:0]       op_q;
    logic             carry_q;
    logic             cout_q;
    logic [IDX_W-1:0] idx;
    logic             last;

    assign last = (idx == IDX_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt     = state;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) state_nxt = RUN;
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, per-slice result/carry update and final carry-out.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx     <= '0;
        end else if (state == IDLE && bus.cmd_valid) begin
            a_q     <= bus.cmd_a;
            b_q     <= bus.cmd_b;
            op_q    <= bus.cmd_op;
            carry_q <= bus.cmd_cin;
            idx     <= '0;
        end else if (state == RUN) begin
            res_q[8*int'(idx) +: 8] <= bus.alu_result;
            carry_q                 <= bus.alu_cout;
            // idx parks on the last slice; it is reloaded on the next capture.
            if (last) cout_q <= bus.alu_cout;
            else      idx    <= idx + IDX_W'(1);
        end
    end

    // Byte-ALU drive: registered slice in RUN, quiet zeros otherwise.
    always_comb begin
        bus.alu_a   = 8'd0;
        bus.alu_b   = 8'd0;
        bus.alu_cin = 1'b0;
        bus.alu_op  = 2'd0;
        if (state == RUN) begin
            bus.alu_a   = a_q[8*int'(idx) +: 8];
            bus.alu_b   = b_q[8*int'(idx) +: 8];
            bus.alu_cin = carry_q;
            bus.alu_op  = op_q;
        end
    end

    assign bus.rsp_result = res_q;
    assign bus.rsp_cout   = cout_q;
    assign bus.rsp_zero   = (res_q == '0);
endmodule

// File: tb/tb_alu32_serial_ctrl.sv
// Bench for alu32_serial_ctrl with a behavioural adder standing in for the byte ALU.
module tb_alu32_serial_ctrl;
    localparam int NB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu32_serial_ctrl_if #(.NBYTES(NB)) bus();

    alu32_serial_ctrl #(.NBYTES(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Byte ALU model: {cout,result} = a + b + cin regardless of op.
    assign {bus.alu_cout, bus.alu_result} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'd0, bus.alu_cin};

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [1:0]  op;
        logic [31:0] res;
        logic        cout;
        logic        zero;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        cout;
        logic        zero;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[5];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit stream_mode = 1'b0;
    int last_hs = -1;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response scoreboard: a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_result", 64'(bus.rsp_result), 64'(mon_e.res));
                check("rsp_cout", 64'(bus.rsp_cout), 64'(mon_e.cout));
                check("rsp_zero", 64'(bus.rsp_zero), 64'(mon_e.zero));
            end
            if (stream_mode && last_hs >= 0) check("rsp_spacing", 64'(cyc - last_hs), 64'd6);
            last_hs = cyc;
        end
    end

    // Present a command and wait (bounded) for acceptance; returns just after the accepting edge.
    task automatic issue(input vec_t v, input bit keep_valid);
        int n;
        exp_t e;
        bus.cmd_a     = v.a;
        bus.cmd_b     = v.b;
        bus.cmd_cin   = v.cin;
        bus.cmd_op    = v.op;
        bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin
            tick();
            n++;
        end
        if (!bus.cmd_ready) check("cmd_ready_timeout", 64'd0, 64'd1);
        e.res  = v.res;
        e.cout = v.cout;
        e.zero = v.zero;
        sb.push_back(e);
        tick();
        if (!keep_valid) bus.cmd_valid = 1'b0;
    endtask

    // Full command: per-slice ALU drive checks, exact latency, then one-cycle response accept.
    task automatic run_vec(input vec_t v);
        logic       c;
        logic [7:0] ab, bb, sum;
        issue(v, 1'b0);
        c = v.cin;
        check("run_rsp_valid_low", 64'(bus.rsp_valid), 64'd0);
        check("run_cmd_ready_low", 64'(bus.cmd_ready), 64'd0);
        for (int s = 0; s < NB; s++) begin
            ab = v.a[8*s +: 8];
            bb = v.b[8*s +: 8];
            check($sformatf("alu_a_s%0d", s), 64'(bus.alu_a), 64'(ab));
            check($sformatf("alu_b_s%0d", s), 64'(bus.alu_b), 64'(bb));
            check($sformatf("alu_cin_s%0d", s), 64'(bus.alu_cin), 64'(c));
            check($sformatf("alu_op_s%0d", s), 64'(bus.alu_op), 64'(v.op));
            {c, sum} = {1'b0, ab} + {1'b0, bb} + {8'd0, c};
            tick();
        end
        check("latency_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("done_alu_a_zero", 64'(bus.alu_a), 64'd0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("post_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("post_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    endtask

    initial begin
        vec_t v;
        int   n;
        logic [31:0] ra, rb;
        logic        rc;

        vecs[0] = '{a: 32'h000000FF, b: 32'h00000001, cin: 1'b0, op: 2'd0, res: 32'h00000100, cout: 1'b0, zero: 1'b0};
        vecs[1] = '{a: 32'hFFFFFFFF, b: 32'h00000001, cin: 1'b0, op: 2'd1, res: 32'h00000000, cout: 1'b1, zero: 1'b1};
        vecs[2] = '{a: 32'h80000000, b: 32'h80000000, cin: 1'b1, op: 2'd2, res: 32'h00000001, cout: 1'b1, zero: 1'b0};
        vecs[3] = '{a: 32'hDEADBEEF, b: 32'h01010101, cin: 1'b0, op: 2'd3, res: 32'hDFAEBFF0, cout: 1'b0, zero: 1'b0};
        vecs[4] = '{a: 32'h00000000, b: 32'h00000000, cin: 1'b0, op: 2'd0, res: 32'h00000000, cout: 1'b0, zero: 1'b1};

        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_cin   = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.rsp_ready = 1'b0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_alu_a", 64'(bus.alu_a), 64'd0);
        check("rst_alu_b", 64'(bus.alu_b), 64'd0);
        check("rst_alu_cin", 64'(bus.alu_cin), 64'd0);
        check("rst_alu_op", 64'(bus.alu_op), 64'd0);
        check("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
        check("rst_rsp_cout", 64'(bus.rsp_cout), 64'd0);
        check("rst_rsp_zero", 64'(bus.rsp_zero), 64'd1);

        // Table-driven commands
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);
        check("table_sb_empty", 64'(sb.size()), 64'd0);

        // Back-pressure: response held while cmd_valid stays high
        v = '{a: 32'h12345678, b: 32'h11111111, cin: 1'b1, op: 2'd1, res: 32'h2345678A, cout: 1'b0, zero: 1'b0};
        issue(v, 1'b1);
        bus.cmd_a = 32'hAAAAAAAA;
        bus.cmd_b = 32'h55555555;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check("hold_rsp_valid_seen", 64'(bus.rsp_valid), 64'd1);
        for (int k = 0; k < 5; k++) begin
            check("hold_rsp_result", 64'(bus.rsp_result), 64'h2345678A);
            check("hold_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            check("hold_cmd_ready", 64'(bus.cmd_ready), 64'd0);
            tick();
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("hold_idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("hold_idle_retain", 64'(bus.rsp_result), 64'h2345678A);
        check("hold_sb_empty", 64'(sb.size()), 64'd0);
        tick();
        check("hold_no_second_cmd", 64'(bus.alu_a), 64'd0);
        check("hold_still_idle", 64'(bus.cmd_ready), 64'd1);

        // Reset mid-command aborts without a response
        v = '{a: 32'h00000005, b: 32'h00000003, cin: 1'b0, op: 2'd0, res: 32'h00000008, cout: 1'b0, zero: 1'b0};
        issue(v, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        bus.rsp_ready = 1'b1;
        tick();
        rst = 1'b0;
        bus.rsp_ready = 1'b0;
        check("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("abort_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("abort_rsp_result", 64'(bus.rsp_result), 64'd0);
        check("abort_rsp_zero", 64'(bus.rsp_zero), 64'd1);
        check("abort_alu_a", 64'(bus.alu_a), 64'd0);
        sb.delete();
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.rsp_valid) check("abort_spurious_rsp", 64'd1, 64'd0);
        end
        v = '{a: 32'h00000001, b: 32'h00000001, cin: 1'b0, op: 2'd0, res: 32'h00000002, cout: 1'b0, zero: 1'b0};
        run_vec(v);
        check("abort_sb_empty", 64'(sb.size()), 64'd0);

        // Streaming: continuous valid/ready, one response every NB+2 cycles
        stream_mode   = 1'b1;
        last_hs       = -1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'(i % 2);
            v.a   = ra;
            v.b   = rb;
            v.cin = rc;
            v.op  = 2'(i);
            {v.cout, v.res} = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
            v.zero = (v.res == 32'd0);
            issue(v, 1'b1);
        end
        bus.cmd_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        check("stream_sb_drained", 64'(sb.size()), 64'd0);
        stream_mode   = 1'b0;
        bus.rsp_ready = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
